scalable_display_driver: RTL
============================

SCALABLE_DISPLAY_DRIVER -- requirements
Module: scalable_display_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of 7-segment digits driven (range 1..8).
REQ-002 Parameter BIN_WIDTH, default 14, width of the unsigned binary input (range 1..27).
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit (at least 2).
REQ-004 clk  input  1  system clock, 100 MHz; the block SHALL use one clock only.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 value  input  BIN_WIDTH  unsigned binary number to display.
REQ-007 load  input  1  single-cycle strobe that captures value.
REQ-008 blank_lz  input  1  1 = blank leading zeros.
REQ-009 dp_mask  input  NUM_DIGITS  decimal point enable per digit; bit i maps to digit i (digit 0 = least significant).
REQ-010 busy  output  1  conversion in progress.
REQ-011 overflow  output  1  last loaded value is at least 10^NUM_DIGITS.
REQ-012 seg  output  7  segment drive, {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  output  1  decimal point drive, active-low.
REQ-014 an  output  NUM_DIGITS  common-anode enables, active-low, one-hot.

Function
REQ-015 FSM states SHALL be IDLE, CONVERT and COMMIT; the FSM SHALL leave reset in IDLE.
REQ-016 IDLE to CONVERT: on load=1; value captured; shift counter cleared; BCD scratch cleared; busy=1 from the next cycle.
REQ-017 CONVERT: one double-dabble iteration per cycle (add 3 to each nibble that is 5 or more, then shift left by 1 bit); exactly BIN_WIDTH iterations; then COMMIT.
REQ-018 COMMIT (1 cycle): scratch copied to the digit registers, overflow updated, busy=0 on the next cycle; then IDLE.
REQ-019 Latency: digit registers update BIN_WIDTH+2 cycles after the load edge.
REQ-020 load while busy=1 SHALL be ignored; no queueing; the digits being displayed stay unchanged until COMMIT.
REQ-021 BCD scratch width SHALL be 4*ceil((BIN_WIDTH+3)/3) bits so the full input range converts without loss.
REQ-022 overflow=1 if any scratch nibble above digit NUM_DIGITS-1 is non-zero; while overflow=1 every digit SHALL show a dash (seg=7'b0111111) and dp SHALL be 1.
REQ-023 Refresh counter counts 0..REFRESH_DIV-1; at the terminal count the digit index advances, and wraps from NUM_DIGITS-1 to 0.
REQ-024 an SHALL have bit [index] low and all other bits high; seg and dp SHALL be registered together with an so they change on the same edge.
REQ-025 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-026 Leading-zero blanking: if blank_lz=1, digit i>0 SHALL show blank when it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-027 dp = ~dp_mask[index]; dp SHALL be driven even on a blanked digit.
REQ-028 blank_lz and dp_mask SHALL take effect at the next digit refresh without a new load.

Reset
REQ-029 On rst, outputs SHALL be: seg=7'h7F, dp=1, an=all 1, busy=0, overflow=0.
REQ-030 On rst, internal state SHALL be: digit registers=0, refresh counter=0, digit index=0, FSM=IDLE.
REQ-031 rst asserted mid-conversion SHALL abort the conversion and discard the partial result.
REQ-032 The first digit SHALL be lit at the first refresh terminal count after rst deasserts.

Structure
REQ-033 Package display_pkg SHALL hold: the 7-bit segment typedef, the decode constants from REQ-025 plus DASH and BLANK, the FSM state enum, and a constant function pow10().
REQ-034 The iterative converter SHALL be the sub-module seq_double_dabble (ports start, bin, bcd, done).
REQ-035 Decode, blanking and scanning logic SHALL stay in the top module.

Verification (NUM_DIGITS=4, BIN_WIDTH=14, REFRESH_DIV=4)
REQ-036 Scenario 1: load value=1234. Required: busy high for 15 cycles; an sequence 1110, 1101, 1011, 0111, each for 4 clocks; seg sequence 0011001, 0110000, 0100100, 1111001.
REQ-037 Scenario 2: value=7, blank_lz=1. Required: digits 3..1 seg=1111111, digit 0 seg=1111000. Then value=0: only digit 0 lit, showing 1000000.
REQ-038 Scenario 3: value=10000. Required: overflow=1, every digit 0111111, dp=1. Then value=9999: overflow=0, every digit 0010000.
REQ-039 Scenario 4: load 1234, then load 5678 three cycles later. Required: the second load is ignored and the display shows 1234.
REQ-040 Scenario 5: dp_mask=4'b0100 with no new load. Required: dp=0 only while an=1011.
REQ-041 Scenario 6: assert rst during CONVERT of value=4321. Required: all outputs immediately at reset values; after release the display shows 0000, or 0 alone with blank_lz=1.

Source files
------------

// File: rtl/scalable_display_driver_pkg.sv
// Shared types and constants for the scanned 7-segment display driver:
// segment patterns, converter FSM states and a power-of-ten helper.
package display_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-low

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seq_double_dabble.sv
// Iterative binary-to-BCD converter: one add-3/shift step per clock,
// BIN_WIDTH steps per conversion; done is high during the final step.
module seq_double_dabble #(
  parameter int BIN_WIDTH = 14,
  parameter int BCD_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic [BCD_WIDTH-1:0] bcd,
  output logic                 done
);

  localparam int NIBS  = BCD_WIDTH / 4;
  localparam int CNT_W = $clog2(BIN_WIDTH) + 1;

  logic [BIN_WIDTH-1:0] r_bin;
  logic [BCD_WIDTH-1:0] r_bcd;
  logic [BCD_WIDTH-1:0] w_adj;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_run;
  logic                 w_last;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NIBS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_last = r_run && (r_cnt == CNT_W'(BIN_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= {w_adj[BCD_WIDTH-2:0], r_bin[BIN_WIDTH-1]};
      r_bin <= r_bin << 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_run <= 1'b0;
    end
  end

  assign bcd  = r_bcd;
  assign done = w_last;

endmodule

// File: rtl/scalable_display_driver.sv
// Converts a loaded binary value to BCD and scans it across NUM_DIGITS
// common-anode 7-segment digits with leading-zero blanking and overflow dashes.
module scalable_display_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * ((BIN_WIDTH + 5) / 3);
  localparam int NIBS  = BCD_W / 4;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);

  state_t r_state, w_next_state;
  logic   w_start, w_done, w_commit;
  logic [BCD_W-1:0]                r_unused_guard;
  logic [BCD_W-1:0]                w_bcd;
  logic [NUM_DIGITS-1:0][3:0]      r_digits, w_new_digits;
  logic                            r_overflow, w_ovf;

  // load is a one-cycle strobe honoured only in IDLE; anything seen while
  // busy is dropped, and busy stays high from the accepting edge to COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_start      = 1'b1;
          w_next_state = CONVERT;
        end
      end
      CONVERT: if (w_done) w_next_state = COMMIT;
      COMMIT: begin
        w_commit     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  seq_double_dabble #(
    .BIN_WIDTH(BIN_WIDTH),
    .BCD_WIDTH(BCD_W)
  ) u_dd (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .bin  (value),
    .bcd  (w_bcd),
    .done (w_done)
  );

  assign r_unused_guard = '0;

  genvar g;
  for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
    if (g < NIBS) begin : g_src
      assign w_new_digits[g] = w_bcd[4*g +: 4];
    end else begin : g_zero
      assign w_new_digits[g] = 4'd0;
    end
  end

  if (NIBS > NUM_DIGITS) begin : g_ovf
    assign w_ovf = |w_bcd[BCD_W-1:4*NUM_DIGITS];
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else if (w_commit) begin
      r_digits   <= w_new_digits;
      r_overflow <= w_ovf;
    end
  end

  function automatic seg_t decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = SEG_0;
      4'd1:    decode = SEG_1;
      4'd2:    decode = SEG_2;
      4'd3:    decode = SEG_3;
      4'd4:    decode = SEG_4;
      4'd5:    decode = SEG_5;
      4'd6:    decode = SEG_6;
      4'd7:    decode = SEG_7;
      4'd8:    decode = SEG_8;
      4'd9:    decode = SEG_9;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  logic [REF_W-1:0]      r_ref;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_tc;
  logic [NUM_DIGITS-1:0] w_zero_hi;
  logic                  w_acc;
  seg_t                  r_seg, w_seg;
  logic                  r_dp, w_dp;
  logic [NUM_DIGITS-1:0] r_an, w_an;

  // w_zero_hi[i] is set when digit i and every digit above it are zero.
  always_comb begin
    w_zero_hi = '0;
    w_acc     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_acc        = w_acc & (r_digits[i] == 4'd0);
      w_zero_hi[i] = w_acc;
    end
  end

  assign w_tc = (r_ref == REF_W'(REFRESH_DIV - 1));
  assign w_an = ~(NUM_DIGITS'(1) << r_idx);

  always_comb begin
    w_seg = decode(r_digits[r_idx]);
    w_dp  = ~dp_mask[r_idx];
    if (r_overflow) begin
      w_seg = SEG_DASH;
      w_dp  = 1'b1;
    end else if (blank_lz && (r_idx != '0) && w_zero_hi[r_idx]) begin
      w_seg = SEG_BLANK;
    end
  end

  // Outputs latch the digit at r_idx on the terminal count, so the first
  // digit lights on the first terminal count after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= '0;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else if (w_tc) begin
      r_ref <= '0;
      r_seg <= w_seg;
      r_dp  <= w_dp;
      r_an  <= w_an;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;
  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;

endmodule
